// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: run-time configurable AXI-Stream packet source.
// It throttles valid with an LFSR, offers counter/LFSR/constant data
// patterns, routes packets round-robin over N_CH destinations, and counts
// handshaken beats and stall cycles.
//
// state | meaning
// IDLE  | waiting for start; counters hold the previous run's totals
// GAP   | run active, no beat presented; one throttle draw per cycle
// BEAT  | beat presented on s_*, held stable until s_ready
// FIN   | one-cycle done pulse, then back to IDLE
module axis_traffic_gen #(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 8,
    parameter int N_CH   = 1,
    parameter int LEN_W  = 16,
    localparam int WPB    = BUS_W / WORD_W,
    localparam int DEST_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_n_words,
    input  logic [LEN_W-1:0]        cfg_n_packets,
    input  logic [1:0]              cfg_mode,
    input  logic [WORD_W-1:0]       cfg_const,
    input  logic [8:0]              cfg_prob_valid,
    input  logic [31:0]             cfg_seed,
    input  logic                    s_ready,
    output logic                    s_valid,
    output logic                    s_last,
    output logic [WPB-1:0]          s_keep,
    output logic [WPB*WORD_W-1:0]   s_data,
    output logic [DEST_W-1:0]       s_dest,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             beat_count,
    output logic [31:0]             stall_count
);

    typedef enum logic [1:0] {IDLE, GAP, BEAT, FIN} state_t;

    localparam logic [31:0]        TAPS     = 32'h8020_0003;
    localparam logic [LEN_W-1:0]   WPB_L    = LEN_W'(WPB);
    localparam logic [DEST_W-1:0]  DEST_MAX = DEST_W'(N_CH - 1);

    state_t                 state, state_nx;
    logic [LEN_W-1:0]       n_words_q, words_left, packets_left;
    logic [1:0]             mode_q;
    logic [WORD_W-1:0]      const_q;
    logic [8:0]             prob_q;
    logic [31:0]            thr_lfsr, data_lfsr, lfsr_v;
    logic [31:0]            seed_thr, seed_dat;
    logic [WORD_W-1:0]      word_cnt, cnt_nx;
    logic [DEST_W-1:0]      pkt_dest;
    logic                   final_q;
    logic [WPB*WORD_W-1:0]  ld_data;
    logic [WPB-1:0]         ld_keep;
    logic                   ld_last, ld_final;
    logic                   issue, hs, start_run, load, thr_adv;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
    endfunction

    assign s_valid = (state == BEAT);
    assign busy    = (state == GAP) || (state == BEAT);
    assign done    = (state == FIN);
    assign hs      = (state == BEAT) && s_ready;
    assign issue   = (prob_q == 9'd256) || ({1'b0, thr_lfsr[7:0]} < prob_q);

    // A zero seed would lock the LFSR, so it is replaced by 1.
    assign seed_thr = (cfg_seed == 32'd0) ? 32'd1 : cfg_seed;
    assign seed_dat = ((cfg_seed ^ 32'hA5A5_A5A5) == 32'd0) ? 32'd1
                                                            : (cfg_seed ^ 32'hA5A5_A5A5);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and control strobes.
    always_comb begin
        state_nx  = state;
        start_run = 1'b0;
        load      = 1'b0;
        thr_adv   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_run = 1'b1;
                    state_nx  = (cfg_n_words == '0 || cfg_n_packets == '0) ? FIN : GAP;
                end
            end
            GAP: begin
                thr_adv = 1'b1;
                if (issue) begin
                    load     = 1'b1;
                    state_nx = BEAT;
                end
            end
            BEAT: begin
                if (s_ready) begin
                    thr_adv = 1'b1;
                    if (final_q)    state_nx = FIN;
                    else if (issue) load     = 1'b1;
                    else            state_nx = GAP;
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Build the next beat from the packet position and the data pattern.
    always_comb begin
        ld_last  = (words_left <= WPB_L);
        ld_final = ld_last && (packets_left == LEN_W'(1));
        ld_data  = '0;
        ld_keep  = '0;
        lfsr_v   = data_lfsr;
        for (int i = 0; i < WPB; i++) begin
            if (!ld_last || (32'(i) < 32'(words_left))) begin
                ld_keep[i] = 1'b1;
                case (mode_q)
                    2'd1: begin
                        ld_data[i*WORD_W +: WORD_W] = lfsr_v[WORD_W-1:0];
                        lfsr_v = lfsr_step(lfsr_v);
                    end
                    2'd2:    ld_data[i*WORD_W +: WORD_W] = const_q;
                    default: ld_data[i*WORD_W +: WORD_W] = word_cnt + WORD_W'(i);
                endcase
            end
        end
        cnt_nx = ld_last ? (word_cnt + WORD_W'(words_left)) : (word_cnt + WORD_W'(WPB));
    end

    // Configuration latch, LFSRs, packet position and beat registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_words_q    <= '0;
            words_left   <= '0;
            packets_left <= '0;
            mode_q       <= '0;
            const_q      <= '0;
            prob_q       <= '0;
            thr_lfsr     <= 32'd1;
            data_lfsr    <= 32'd1;
            word_cnt     <= '0;
            pkt_dest     <= '0;
            final_q      <= 1'b0;
            s_data       <= '0;
            s_keep       <= '0;
            s_last       <= 1'b0;
            s_dest       <= '0;
        end else if (start_run) begin
            n_words_q    <= cfg_n_words;
            words_left   <= cfg_n_words;
            packets_left <= cfg_n_packets;
            mode_q       <= cfg_mode;
            const_q      <= cfg_const;
            prob_q       <= cfg_prob_valid;
            thr_lfsr     <= seed_thr;
            data_lfsr    <= seed_dat;
            word_cnt     <= '0;
            pkt_dest     <= '0;
            final_q      <= 1'b0;
            s_dest       <= '0;
        end else begin
            if (thr_adv) thr_lfsr <= lfsr_step(thr_lfsr);
            if (load) begin
                s_data    <= ld_data;
                s_keep    <= ld_keep;
                s_last    <= ld_last;
                s_dest    <= pkt_dest;
                final_q   <= ld_final;
                data_lfsr <= lfsr_v;
                word_cnt  <= cnt_nx;
                if (ld_last) begin
                    words_left   <= n_words_q;
                    packets_left <= packets_left - LEN_W'(1);
                    pkt_dest     <= (pkt_dest == DEST_MAX) ? '0 : pkt_dest + DEST_W'(1);
                end else begin
                    words_left <= words_left - WPB_L;
                end
            end
        end
    end

    // Saturating beat and stall counters, cleared at the start of a run.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else if (start_run) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (hs && beat_count != 32'hFFFF_FFFF)
                beat_count <= beat_count + 32'd1;
            if (state == BEAT && !s_ready && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_axis_traffic_gen.sv
// Scoreboard bench: stimulus pushes expected beats, monitors pop and compare.
module tb_axis_traffic_gen;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic [1:0]  dest;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        ready_a = 1'b1, ready_b = 1'b1;
    logic [15:0] cfg_n_words = '0, cfg_n_packets = '0;
    logic [1:0]  cfg_mode = '0;
    logic [7:0]  cfg_const = '0;
    logic [8:0]  cfg_prob_valid = '0;
    logic [31:0] cfg_seed = '0;

    logic        a_valid, a_last, a_busy, a_done;
    logic [3:0]  a_keep;
    logic [31:0] a_data, a_beats, a_stalls;
    logic [1:0]  a_dest;
    logic        b_valid, b_last, b_busy, b_done;
    logic [0:0]  b_keep;
    logic [7:0]  b_data;
    logic [0:0]  b_dest;
    logic [31:0] b_beats, b_stalls;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    beat_t qa[$];
    beat_t qb[$];
    int    b_hs[$];
    int    a_first_hs = -1, a_last_hs = -1, a_valid_n = 0;

    axis_traffic_gen #(.WORD_W(8), .BUS_W(32), .N_CH(3), .LEN_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .start(start_a),
        .cfg_n_words(cfg_n_words), .cfg_n_packets(cfg_n_packets),
        .cfg_mode(cfg_mode), .cfg_const(cfg_const),
        .cfg_prob_valid(cfg_prob_valid), .cfg_seed(cfg_seed),
        .s_ready(ready_a), .s_valid(a_valid), .s_last(a_last), .s_keep(a_keep),
        .s_data(a_data), .s_dest(a_dest), .busy(a_busy), .done(a_done),
        .beat_count(a_beats), .stall_count(a_stalls)
    );

    axis_traffic_gen #(.WORD_W(8), .BUS_W(8), .N_CH(1), .LEN_W(16)) dut_b (
        .clk(clk), .rstn(rstn), .start(start_b),
        .cfg_n_words(cfg_n_words), .cfg_n_packets(cfg_n_packets),
        .cfg_mode(cfg_mode), .cfg_const(cfg_const),
        .cfg_prob_valid(cfg_prob_valid), .cfg_seed(cfg_seed),
        .s_ready(ready_b), .s_valid(b_valid), .s_last(b_last), .s_keep(b_keep),
        .s_data(b_data), .s_dest(b_dest), .busy(b_busy), .done(b_done),
        .beat_count(b_beats), .stall_count(b_stalls)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic push_a(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [1:0] dst);
        beat_t e;
        e.data = d; e.keep = k; e.last = l; e.dest = dst;
        qa.push_back(e);
    endtask

    // Monitor A: scoreboard pop on handshake, hold check while stalled.
    initial begin
        beat_t    e;
        logic     prev_stall;
        logic [38:0] prev_bundle;
        prev_stall = 1'b0;
        prev_bundle = '0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (a_valid) a_valid_n++;
                if (prev_stall)
                    check("hold_a", {a_data, a_keep, a_last, a_dest}, prev_bundle);
                if (a_valid && ready_a) begin
                    if (a_first_hs < 0) a_first_hs = cyc;
                    a_last_hs = cyc;
                    check("beat_a_expected", qa.size() != 0, 1);
                    if (qa.size() != 0) begin
                        e = qa.pop_front();
                        check("data_a", a_data, e.data);
                        check("keep_a", a_keep, e.keep);
                        check("last_a", a_last, e.last);
                        check("dest_a", a_dest, e.dest);
                    end
                end
                prev_stall  = a_valid && !ready_a;
                prev_bundle = {a_data, a_keep, a_last, a_dest};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Monitor B: scoreboard pop on handshake, records handshake cycles.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rstn && b_valid && ready_b) begin
                b_hs.push_back(cyc);
                check("beat_b_expected", qb.size() != 0, 1);
                if (qb.size() != 0) begin
                    e = qb.pop_front();
                    check("data_b", b_data, e.data);
                    check("keep_b", {3'b000, b_keep}, e.keep);
                    check("last_b", b_last, e.last);
                    check("dest_b", {1'b0, b_dest}, e.dest);
                end
            end
        end
    end

    task automatic run(input logic sel, input int nw, input int np, input int mode,
                       input int prob, input logic [31:0] seed, output int s);
        @(posedge clk); #1;
        cfg_n_words = 16'(nw); cfg_n_packets = 16'(np); cfg_mode = 2'(mode);
        cfg_prob_valid = 9'(prob); cfg_seed = seed;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        a_first_hs = -1; a_last_hs = -1;
        s = cyc;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_done(input logic sel, input int limit, output int d);
        d = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if ((sel ? b_done : a_done) == 1'b1) begin
                d = cyc;
                break;
            end
        end
        check(sel ? "done_b_seen" : "done_a_seen", sel ? b_done : a_done, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, s2;
        int offs[$];
        int r1[$];
        logic [31:0] m;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", a_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_done", a_done, 0);
        check("rst_data", a_data, 0);
        check("rst_keep", a_keep, 0);
        check("rst_beats", a_beats, 0);
        check("rst_stalls", a_stalls, 0);
        rstn = 1'b1;

        // 10 words, one packet, back-to-back
        ready_a = 1'b1;
        push_a(32'h03020100, 4'hF, 1'b0, 2'd0);
        push_a(32'h07060504, 4'hF, 1'b0, 2'd0);
        push_a(32'h00000908, 4'h3, 1'b1, 2'd0);
        run(1'b0, 10, 1, 0, 256, 32'd1, s);
        wait_done(1'b0, 50, d);
        check("t1_first_hs", a_first_hs, s + 2);
        check("t1_last_hs", a_last_hs, s + 4);
        check("t1_done_cyc", d, s + 5);
        check("t1_beats", a_beats, 3);
        check("t1_stalls", a_stalls, 0);
        check("t1_busy_at_done", a_busy, 0);
        @(negedge clk);
        check("t1_done_one_cycle", a_done, 0);
        check("t1_queue_empty", qa.size(), 0);

        // Same config, 5 stall cycles on beat 2
        push_a(32'h03020100, 4'hF, 1'b0, 2'd0);
        push_a(32'h07060504, 4'hF, 1'b0, 2'd0);
        push_a(32'h00000908, 4'h3, 1'b1, 2'd0);
        run(1'b0, 10, 1, 0, 256, 32'd1, s);
        for (int i = 0; i < 20 && a_beats == 0; i++) begin
            @(posedge clk); #1;
        end
        check("t2_beat1", a_beats, 1);
        ready_a = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_a = 1'b1;
        wait_done(1'b0, 50, d);
        check("t2_stalls", a_stalls, 5);
        check("t2_beats", a_beats, 3);
        check("t2_queue_empty", qa.size(), 0);

        // Four packets of four words, dest rotation over 3 channels;
        // a start with different config mid-run must be ignored
        push_a(32'h03020100, 4'hF, 1'b1, 2'd0);
        push_a(32'h07060504, 4'hF, 1'b1, 2'd1);
        push_a(32'h0B0A0908, 4'hF, 1'b1, 2'd2);
        push_a(32'h0F0E0D0C, 4'hF, 1'b1, 2'd0);
        run(1'b0, 4, 4, 0, 256, 32'd1, s);
        for (int i = 0; i < 20 && a_beats == 0; i++) begin
            @(posedge clk); #1;
        end
        cfg_n_words = 16'd1; cfg_n_packets = 16'd9; cfg_mode = 2'd2; cfg_const = 8'hEE;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_done(1'b0, 50, d);
        check("t3_first_hs", a_first_hs, s + 2);
        check("t3_last_hs", a_last_hs, s + 5);
        check("t3_beats", a_beats, 4);
        check("t3_queue_empty", qa.size(), 0);

        // Zero-length runs finish immediately
        a_valid_n = 0;
        run(1'b0, 0, 1, 0, 256, 32'd1, s);
        wait_done(1'b0, 10, d);
        check("t4_done_cyc", d, s + 1);
        check("t4_beats", a_beats, 0);
        run(1'b0, 3, 0, 0, 256, 32'd1, s);
        wait_done(1'b0, 10, d);
        check("t4b_done_cyc", d, s + 1);
        repeat (5) @(negedge clk);
        check("t4_no_valid", a_valid_n, 0);

        // prob=0 parks in GAP until reset
        run(1'b0, 4, 1, 0, 0, 32'd1, s);
        begin
            int nv, nb;
            nv = 0; nb = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (a_valid) nv++;
                if (!a_busy) nb++;
            end
            check("t5_no_valid", nv, 0);
            check("t5_busy_held", nb, 0);
        end
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_valid", a_valid, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Reset in the middle of a stalled beat
        ready_a = 1'b0;
        run(1'b0, 4, 1, 0, 256, 32'd1, s);
        for (int i = 0; i < 20 && !a_valid; i++) begin
            @(posedge clk); #1;
        end
        check("t6_valid_up", a_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        check("t6_stalls_pre", a_stalls, 2);
        rstn = 1'b0;
        #1;
        check("t6_rst_valid", a_valid, 0);
        check("t6_rst_data", a_data, 0);
        check("t6_rst_keep", a_keep, 0);
        check("t6_rst_busy", a_busy, 0);
        check("t6_rst_stalls", a_stalls, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        ready_a = 1'b1;

        // LFSR data with throttling on the 8-bit instance
        begin
            logic [31:0] t;
            t = 32'd1;
            for (int j = 0; offs.size() < 16 && j < 2000; j++) begin
                if (t[7:0] < 8'd128) offs.push_back(j + 2);
                t = lfsr_ref(t);
            end
        end
        for (int pass = 0; pass < 2; pass++) begin
            m = 32'hA5A5A5A4;
            for (int k = 0; k < 16; k++) begin
                beat_t e;
                e.data = {24'd0, m[7:0]}; e.keep = 4'b0001; e.last = (k == 15); e.dest = 2'd0;
                qb.push_back(e);
                m = lfsr_ref(m);
            end
            b_hs.delete();
            run(1'b1, 16, 1, 1, 128, 32'd1, s2);
            wait_done(1'b1, 500, d);
            check("t7_beats", b_beats, 16);
            check("t7_hs_count", b_hs.size(), 16);
            check("t7_queue_empty", qb.size(), 0);
            if (b_hs.size() == 16) begin
                check("t7_gap_seen", (b_hs[15] - b_hs[0]) > 15, 1);
                for (int k = 0; k < 16; k++) begin
                    check("t7_timing_model", b_hs[k] - s2, offs[k]);
                    if (pass == 0) r1.push_back(b_hs[k] - s2);
                    else           check("t7_timing_rerun", b_hs[k] - s2, r1[k]);
                end
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
